// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
// Operation encoding, FSM states and iteration count.
package muldiv_pkg;

  typedef logic [31:0] i32;
  typedef logic [63:0] i64;
  typedef logic        i1;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  localparam int DIV_ITERS = 32;

  function automatic i1 is_div(muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_core.sv
// Unsigned radix-2 restoring divider, one iteration per enable.
// Signs are resolved by the caller; this core sees magnitudes only.
module div_core
  import muldiv_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic init,
  input  logic en,
  input  i32   dividend,
  input  i32   divisor,
  output i32   quo,
  output i32   rem
);

  i32          quo_q;
  i32          rem_q;
  i32          dvs_q;
  logic [32:0] r_sh;
  logic [32:0] diff;

  // Shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    r_sh = {rem_q, quo_q[31]};
    diff = r_sh - {1'b0, dvs_q};
  end

  // Remainder/quotient shift registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (init) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (en) begin
      if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= r_sh[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  assign quo = quo_q;
  assign rem = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer writing the HI/LO pair.
// MULDIV_DIV0_FAST_EN: divide-by-zero skips the iterations.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  muldiv_op_t op,
  input  i32         a,
  input  i32         b,
  input  logic       flush,
  output logic       busy,
  output logic       done,
  output logic       hi_write,
  output logic       lo_write,
  output i32         hi_data,
  output i32         lo_data
);

  md_state_t  state;
  logic [4:0] cnt;
  i32         a_q;
  i32         b_q;
  muldiv_op_t op_q;
  i64         prod_q;

  logic accept;
  logic div0_fast;
  logic div_init;
  logic div_en;
  i64   prod;
  i32   abs_a;
  i32   abs_b;
  i32   quo;
  i32   rem;
  i32   hi_r;
  i32   lo_r;
  logic in_done;

  assign accept = (state == ST_IDLE) && start && !flush;

`ifdef MULDIV_DIV0_FAST_EN
  assign div0_fast = (b == '0);
`else
  assign div0_fast = 1'b0;
`endif

  // Full-width product and divider magnitudes from the live operands.
  always_comb begin
    if (op == MD_MULT)
      prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    else
      prod = {32'b0, a} * {32'b0, b};
    abs_a = (op == MD_DIV && a[31]) ? -a : a;
    abs_b = (op == MD_DIV && b[31]) ? -b : b;
  end

  assign div_init = accept && is_div(op);
  assign div_en   = (state == ST_DIV) && !flush;

  div_core u_div (
    .clk      (clk),
    .resetn   (resetn),
    .init     (div_init),
    .en       (div_en),
    .dividend (abs_a),
    .divisor  (abs_b),
    .quo      (quo),
    .rem      (rem)
  );

  // Sequencer: accept, count latency or iterations, one write cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= MD_MULT;
      prod_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            if (is_div(op)) begin
              cnt   <= 5'(DIV_ITERS - 1);
              state <= div0_fast ? ST_DONE : ST_DIV;
            end else begin
              prod_q <= prod;
              cnt    <= 5'(MUL_LAT - 1);
              state  <= (MUL_LAT == 1) ? ST_DONE : ST_MUL;
            end
          end
        end
        ST_MUL: begin
          if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt <= 5'd1) begin
            state <= ST_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        ST_DIV: begin
          if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == 5'd0) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Sign fix-up and divide-by-zero override on the stored results.
  always_comb begin
    hi_r = prod_q[63:32];
    lo_r = prod_q[31:0];
    if (is_div(op_q)) begin
      if (b_q == '0) begin
        hi_r = a_q;
        lo_r = 32'hFFFF_FFFF;
      end else if (op_q == MD_DIV) begin
        lo_r = (a_q[31] ^ b_q[31]) ? -quo : quo;
        hi_r = a_q[31] ? -rem : rem;
      end else begin
        lo_r = quo;
        hi_r = rem;
      end
    end
  end

  assign in_done  = (state == ST_DONE);
  assign busy     = (state != ST_IDLE);
  assign done     = in_done && !flush;
  assign hi_write = done;
  assign lo_write = done;
  assign hi_data  = in_done ? hi_r : '0;
  assign lo_data  = in_done ? lo_r : '0;

endmodule
